alu_sched: RTL and testbench

- Two-requester round-robin scheduler that shares one 4-bit `alu` instance (ops add, sub, compare, and, or, not, inc, dec).
- Each requester presents operands and a 3-bit opcode with a valid/ready handshake.
- The scheduler grants one requester, drives the shared ALU and registers the result.
- It returns the result on a single response channel tagged with the requester id.

---
 rtl/alu_sched.sv | 144 ++++++++++++++
 tb/tb_alu_sched.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_sched.sv
// Two-requester round-robin scheduler sharing one 4-bit ALU, with a tagged response channel.
// Optional per-requester saturating op counters are enabled by defining ALU_SCHED_STATS_EN.
module alu_sched #(
   parameter int unsigned PRIO_INIT = 0
`ifdef ALU_SCHED_STATS_EN
   , parameter int unsigned CNT_W = 8
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [3:0] req0_a,
   input  logic [3:0] req0_b,
   input  logic [2:0] req0_op,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [3:0] req1_a,
   input  logic [3:0] req1_b,
   input  logic [2:0] req1_op,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic       rsp_id,
   output logic [3:0] rsp_r,
   output logic       rsp_flag
`ifdef ALU_SCHED_STATS_EN
   , output logic [CNT_W-1:0] cnt0
   , output logic [CNT_W-1:0] cnt1
`endif
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t     state;
   logic       last_gnt;
   logic       id_q;
   logic [3:0] a_q;
   logic [3:0] b_q;
   logic [2:0] op_q;

   logic       any_valid_c;
   logic       gnt_c;
   logic [3:0] alu_r_c;
   logic       alu_flag_c;
   logic [4:0] sum_c;

   // Grant: lone requester wins; on contention the one not granted last wins.
   always_comb begin
      gnt_c = req1_valid;
      if (req0_valid && req1_valid) begin
         gnt_c = ~last_gnt;
      end
   end

   assign any_valid_c = req0_valid | req1_valid;
   assign req0_ready  = (state == IDLE) && !rst && any_valid_c && !gnt_c;
   assign req1_ready  = (state == IDLE) && !rst && any_valid_c && gnt_c;

   // Shared ALU, fed only from the operand registers; flag is zero for non-arithmetic ops.
   always_comb begin
      alu_r_c    = 4'd0;
      alu_flag_c = 1'b0;
      sum_c      = 5'd0;
      case (op_q)
         3'd0: begin
            sum_c      = {1'b0, a_q} + {1'b0, b_q};
            alu_r_c    = sum_c[3:0];
            alu_flag_c = sum_c[4];
         end
         3'd1: begin
            sum_c      = {1'b0, a_q} + {1'b0, ~b_q} + 5'd1;
            alu_r_c    = sum_c[3:0];
            alu_flag_c = sum_c[4];
         end
         3'd2: alu_r_c = {1'b0, (a_q > b_q), (a_q == b_q), (a_q < b_q)};
         3'd3: alu_r_c = a_q & b_q;
         3'd4: alu_r_c = a_q | b_q;
         3'd5: alu_r_c = ~a_q;
         3'd6: alu_r_c = a_q + 4'd1;
         3'd7: alu_r_c = a_q - 4'd1;
         default: alu_r_c = 4'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_r     <= 4'd0;
         rsp_flag  <= 1'b0;
         last_gnt  <= ~1'(PRIO_INIT);
         id_q      <= 1'b0;
         a_q       <= 4'd0;
         b_q       <= 4'd0;
         op_q      <= 3'd0;
      end else begin
         case (state)
            IDLE: begin
               if (any_valid_c) begin
                  a_q   <= gnt_c ? req1_a  : req0_a;
                  b_q   <= gnt_c ? req1_b  : req0_b;
                  op_q  <= gnt_c ? req1_op : req0_op;
                  id_q  <= gnt_c;
                  state <= EXEC;
               end
            end
            EXEC: begin
               rsp_r     <= alu_r_c;
               rsp_flag  <= alu_flag_c;
               rsp_id    <= id_q;
               last_gnt  <= id_q;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ALU_SCHED_STATS_EN
   // Saturating count of accepted transfers per requester.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else begin
         if (req0_valid && req0_ready && (cnt0 != '1)) begin
            cnt0 <= cnt0 + CNT_W'(1);
         end
         if (req1_valid && req1_ready && (cnt1 != '1)) begin
            cnt1 <= cnt1 + CNT_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched: directed test-plan steps followed by randomized ops against a behavioural model.
// Counter checks are included when ALU_SCHED_STATS_EN is defined.
module tb_alu_sched;

   localparam int unsigned PRIO = 0;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0_valid = 1'b0, req1_valid = 1'b0;
   logic       req0_ready, req1_ready;
   logic [3:0] req0_a = 4'd0, req0_b = 4'd0, req1_a = 4'd0, req1_b = 4'd0;
   logic [2:0] req0_op = 3'd0, req1_op = 3'd0;
   logic       rsp_valid, rsp_id, rsp_flag;
   logic       rsp_ready = 1'b0;
   logic [3:0] rsp_r;
`ifdef ALU_SCHED_STATS_EN
   logic [7:0] cnt0, cnt1;
`endif

   int passed = 0;
   int total  = 0;
   int last_id = -1;
   int cnt_m0 = 0, cnt_m1 = 0;

   alu_sched #(.PRIO_INIT(PRIO)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_r(rsp_r), .rsp_flag(rsp_flag)
`ifdef ALU_SCHED_STATS_EN
      , .cnt0(cnt0), .cnt1(cnt1)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Result and flag straight from the operation definitions: {flag, r}.
   function automatic logic [4:0] ref_alu(input int op, input int a, input int b);
      int r;
      int f;
      r = 0;
      f = 0;
      case (op)
         0: begin r = (a + b) % 16; f = (a + b > 15) ? 1 : 0; end
         1: begin r = (a - b + 16) % 16; f = (a >= b) ? 1 : 0; end
         2: r = ((a > b) ? 4 : 0) + ((a == b) ? 2 : 0) + ((a < b) ? 1 : 0);
         3: r = a & b;
         4: r = a | b;
         5: r = 15 - a;
         6: r = (a + 1) % 16;
         default: r = (a + 15) % 16;
      endcase
      return {f[0], r[3:0]};
   endfunction

   task automatic scramble();
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_a = 4'($urandom); req0_b = 4'($urandom); req0_op = 3'($urandom);
      req1_a = 4'($urandom); req1_b = 4'($urandom); req1_op = 3'($urandom);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      last_id = -1;
      cnt_m0 = 0;
      cnt_m1 = 0;
      #1;
   endtask

   // One transaction starting in IDLE; returns with the DUT back in IDLE.
   task automatic run_op(input logic v0, input logic [3:0] a0, input logic [3:0] b0, input logic [2:0] op0,
                         input logic v1, input logic [3:0] a1, input logic [3:0] b1, input logic [2:0] op1,
                         input int hold);
      int exp_id;
      logic [4:0] e;
      req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
      req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
      rsp_ready = 1'($urandom_range(0, 1));
      #1;
      if (!v0 && !v1) begin
         chk("idle_rdy0", 8'(req0_ready), 8'd0);
         chk("idle_rdy1", 8'(req1_ready), 8'd0);
         chk("idle_rsp_valid", 8'(rsp_valid), 8'd0);
         tick();
         return;
      end
      if (v0 && v1) exp_id = (last_id < 0) ? int'(PRIO) : 1 - last_id;
      else          exp_id = v1 ? 1 : 0;
      chk("accept_rdy0", 8'(req0_ready), (exp_id == 0) ? 8'd1 : 8'd0);
      chk("accept_rdy1", 8'(req1_ready), (exp_id == 1) ? 8'd1 : 8'd0);
      e = (exp_id == 1) ? ref_alu(int'(op1), int'(a1), int'(b1)) : ref_alu(int'(op0), int'(a0), int'(b0));
      if (exp_id == 0 && cnt_m0 < 255) cnt_m0++;
      if (exp_id == 1 && cnt_m1 < 255) cnt_m1++;
      tick();
      scramble();
      rsp_ready = 1'($urandom_range(0, 1));
      #1;
      chk("exec_rdy0", 8'(req0_ready), 8'd0);
      chk("exec_rdy1", 8'(req1_ready), 8'd0);
      chk("exec_rsp_valid", 8'(rsp_valid), 8'd0);
      tick();
      last_id = exp_id;
      for (int i = 0; i <= hold; i++) begin
         scramble();
         rsp_ready = (i == hold) ? 1'b1 : 1'b0;
         #1;
         chk("rsp_valid", 8'(rsp_valid), 8'd1);
         chk("rsp_r", 8'(rsp_r), 8'(e[3:0]));
         chk("rsp_flag", 8'(rsp_flag), 8'(e[4]));
         chk("rsp_id", 8'(rsp_id), 8'(exp_id));
         chk("resp_rdy0", 8'(req0_ready), 8'd0);
         chk("resp_rdy1", 8'(req1_ready), 8'd0);
         tick();
      end
   endtask

   initial begin
      // Reset state
      do_reset();
      chk("reset_rsp_valid", 8'(rsp_valid), 8'd0);
      chk("reset_rsp_id", 8'(rsp_id), 8'd0);
      chk("reset_rsp_r", 8'(rsp_r), 8'd0);
      chk("reset_rsp_flag", 8'(rsp_flag), 8'd0);
      chk("reset_rdy0", 8'(req0_ready), 8'd0);
      chk("reset_rdy1", 8'(req1_ready), 8'd0);

      // Directed ops from the test plan
      run_op(1'b1, 4'd9, 4'd8, 3'd0, 1'b0, 4'd0, 4'd0, 3'd0, 0);
      chk("plan_add_r", 8'(rsp_r), 8'd1);
      run_op(1'b0, 4'd0, 4'd0, 3'd0, 1'b1, 4'd3, 4'd5, 3'd1, 0);
      chk("plan_sub_r", 8'(rsp_r), 8'd14);
      run_op(1'b0, 4'd0, 4'd0, 3'd0, 1'b1, 4'd5, 4'd3, 3'd1, 0);
      chk("plan_sub_flag", 8'(rsp_flag), 8'd1);
      run_op(1'b1, 4'd5, 4'd5, 3'd2, 1'b0, 4'd0, 4'd0, 3'd0, 0);
      chk("plan_cmp_eq", 8'(rsp_r), 8'd2);
      run_op(1'b1, 4'd2, 4'd7, 3'd2, 1'b0, 4'd0, 4'd0, 3'd0, 0);
      chk("plan_cmp_lt", 8'(rsp_r), 8'd1);
      run_op(1'b1, 4'd0, 4'd0, 3'd7, 1'b0, 4'd0, 4'd0, 3'd0, 0);
      chk("plan_dec_wrap", 8'(rsp_r), 8'd15);
      run_op(1'b1, 4'd15, 4'd0, 3'd6, 1'b0, 4'd0, 4'd0, 3'd0, 0);
      chk("plan_inc_wrap", 8'(rsp_r), 8'd0);

      // Contention after reset alternates starting at PRIO_INIT
      do_reset();
      for (int k = 0; k < 4; k++) begin
         run_op(1'b1, 4'(k), 4'd1, 3'd0, 1'b1, 4'(k), 4'd1, 3'd1, 0);
         chk("rr_seq_id", 8'(rsp_id), 8'(k % 2));
      end

      // Stalled consumer for 5 cycles
      run_op(1'b1, 4'd7, 4'd9, 3'd0, 1'b1, 4'd12, 4'd3, 3'd4, 5);

      // Reset during EXEC aborts the op and reinitialises the pointer
      run_op(1'b1, 4'd1, 4'd1, 3'd3, 1'b0, 4'd0, 4'd0, 3'd0, 0);
      req0_valid = 1'b1; req0_a = 4'd4; req0_b = 4'd4; req0_op = 3'd0;
      #1;
      chk("abort_accept", 8'(req0_ready), 8'd1);
      tick();
      rst = 1'b1;
      req0_valid = 1'b0;
      tick();
      rst = 1'b0;
      last_id = -1;
      cnt_m0 = 0;
      cnt_m1 = 0;
      #1;
      chk("abort_rsp_valid", 8'(rsp_valid), 8'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("abort_no_rsp", 8'(rsp_valid), 8'd0);
      end
      run_op(1'b1, 4'd2, 4'd3, 3'd0, 1'b1, 4'd8, 4'd1, 3'd1, 0);

      // Randomized ops against the model
      for (int k = 0; k < 80; k++) begin
         run_op(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 3'($urandom),
                1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 3'($urandom),
                int'($urandom_range(0, 3)));
      end

`ifdef ALU_SCHED_STATS_EN
      chk("cnt0", cnt0, 8'(cnt_m0));
      chk("cnt1", cnt1, 8'(cnt_m1));
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
